// File: rtl/lms_sequencer.sv
// Control sequencer for a time-multiplexed LMS adaptive FIR engine.
// Runs one filter pass per sample, then one coefficient-update pass while the iteration budget lasts.
module lms_sequencer #(
  parameter int TAPS   = 101,
  parameter int ADDR_W = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic signed [31:0]  num_iterations,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                shift_en,
  output logic                mac_clr,
  output logic                mac_en,
  output logic [ADDR_W-1:0]   tap_addr,
  output logic                err_latch,
  output logic                out_valid,
  output logic                coef_we,
  output logic                adapt_active,
  output logic                busy,
  output logic                done,
  output logic [31:0]         iter_count
);

  typedef enum logic [2:0] {IDLE, WAIT, FILTER, ERROR, UPDATE} state_t;

  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(TAPS - 1);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   tap_reg, tap_next;
  logic signed [31:0]  budget_reg, budget_next;
  logic [31:0]         iter_reg, iter_next;
  logic                adapt_reg, adapt_next;
  logic                ready_reg, ready_next;
  logic                shift_reg, shift_next;
  logic                clr_reg, clr_next;
  logic                en_reg, en_next;
  logic                err_reg, err_next;
  logic                we_reg, we_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;

  // Every output is a register loaded from the value it must show in the next cycle.
  always_comb begin
    state_next  = state_reg;
    tap_next    = '0;
    budget_next = budget_reg;
    iter_next   = iter_reg;
    adapt_next  = adapt_reg;
    ready_next  = 1'b0;
    shift_next  = 1'b0;
    clr_next    = 1'b0;
    en_next     = 1'b0;
    err_next    = 1'b0;
    we_next     = 1'b0;
    done_next   = 1'b0;
    if (stop) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            budget_next = num_iterations;
            iter_next   = '0;
            adapt_next  = (num_iterations > 0);
            done_next   = (num_iterations <= 0);
            ready_next  = 1'b1;
            state_next  = WAIT;
          end
        end
        WAIT: begin
          if (s_valid && ready_reg) begin
            shift_next = 1'b1;
            clr_next   = 1'b1;
            en_next    = 1'b1;
            state_next = FILTER;
          end else begin
            ready_next = 1'b1;
          end
        end
        FILTER: begin
          if (tap_reg == LAST_TAP) begin
            err_next   = 1'b1;
            state_next = ERROR;
          end else begin
            tap_next = tap_reg + 1'b1;
            en_next  = 1'b1;
          end
        end
        ERROR: begin
          if (adapt_reg) begin
            we_next    = 1'b1;
            state_next = UPDATE;
          end else begin
            ready_next = 1'b1;
            state_next = WAIT;
          end
        end
        UPDATE: begin
          if (tap_reg == LAST_TAP) begin
            ready_next = 1'b1;
            state_next = WAIT;
            // Saturate: never count past the latched budget.
            if (iter_reg != $unsigned(budget_reg)) begin
              iter_next = iter_reg + 32'd1;
              if (iter_reg + 32'd1 == $unsigned(budget_reg)) begin
                adapt_next = 1'b0;
                done_next  = 1'b1;
              end
            end
          end else begin
            tap_next = tap_reg + 1'b1;
            we_next  = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      tap_reg    <= '0;
      budget_reg <= '0;
      iter_reg   <= '0;
      adapt_reg  <= 1'b0;
      ready_reg  <= 1'b0;
      shift_reg  <= 1'b0;
      clr_reg    <= 1'b0;
      en_reg     <= 1'b0;
      err_reg    <= 1'b0;
      we_reg     <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      tap_reg    <= tap_next;
      budget_reg <= budget_next;
      iter_reg   <= iter_next;
      adapt_reg  <= adapt_next;
      ready_reg  <= ready_next;
      shift_reg  <= shift_next;
      clr_reg    <= clr_next;
      en_reg     <= en_next;
      err_reg    <= err_next;
      we_reg     <= we_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  assign s_ready      = ready_reg;
  assign shift_en     = shift_reg;
  assign mac_clr      = clr_reg;
  assign mac_en       = en_reg;
  assign tap_addr     = tap_reg;
  assign err_latch    = err_reg;
  assign out_valid    = err_reg;
  assign coef_we      = we_reg;
  assign adapt_active = adapt_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign iter_count   = iter_reg;

endmodule

// File: tb/tb_lms_sequencer.sv
// Bench for lms_sequencer: per-cycle scoreboard of expected strobes for a TAPS=4 instance,
// plus a throughput/range run on a TAPS=101 instance.
module tb_lms_sequencer;

  localparam int TAPS   = 4;
  localparam int AW     = 3;
  localparam int TAPS_B = 101;
  localparam int AW_B   = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // TAPS=4 instance
  logic               start, stop, s_valid;
  logic signed [31:0] num;
  logic               s_ready, shift_en, mac_clr, mac_en, err_latch, out_valid, coef_we;
  logic               adapt_active, busy, done;
  logic [AW-1:0]      tap_addr;
  logic [31:0]        iter_count;

  // TAPS=101 instance
  logic               b_start, b_stop, b_valid;
  logic signed [31:0] b_num;
  logic               b_s_ready, b_shift_en, b_mac_clr, b_mac_en, b_err_latch, b_out_valid, b_coef_we;
  logic               b_adapt_active, b_busy, b_done;
  logic [AW_B-1:0]    b_tap_addr;
  logic [31:0]        b_iter_count;

  lms_sequencer #(.TAPS(TAPS), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .num_iterations(num),
    .s_valid(s_valid), .s_ready(s_ready), .shift_en(shift_en), .mac_clr(mac_clr),
    .mac_en(mac_en), .tap_addr(tap_addr), .err_latch(err_latch), .out_valid(out_valid),
    .coef_we(coef_we), .adapt_active(adapt_active), .busy(busy), .done(done),
    .iter_count(iter_count)
  );

  lms_sequencer #(.TAPS(TAPS_B), .ADDR_W(AW_B)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .stop(b_stop), .num_iterations(b_num),
    .s_valid(b_valid), .s_ready(b_s_ready), .shift_en(b_shift_en), .mac_clr(b_mac_clr),
    .mac_en(b_mac_en), .tap_addr(b_tap_addr), .err_latch(b_err_latch), .out_valid(b_out_valid),
    .coef_we(b_coef_we), .adapt_active(b_adapt_active), .busy(b_busy), .done(b_done),
    .iter_count(b_iter_count)
  );

  typedef struct packed {
    logic          sh, clr, en;
    logic [AW-1:0] tap;
    logic          err, ov, we, rdy, bsy, dn;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
    bit   inc;
  } ent_t;

  typedef struct {
    int num;
    int samples;
    bit rnd;
    int exp_we, exp_ov, exp_done, exp_iter;
    bit exp_adapt;
  } vec_t;

  ent_t q[$];
  int   n_vec = 0, n_fail = 0, cyc = 0;
  bit   mon_en = 0, m_running = 0, m_adapt = 0;
  int   m_budget = 0, m_iter = 0, m_planned = 0, m_accepts = 0, m_last_acc = 0;
  int   cnt_we = 0, cnt_ov = 0, cnt_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(int c, obs_t o, bit inc);
    ent_t e;
    e.cyc = c;
    e.o   = o;
    e.inc = inc;
    q.push_back(e);
  endfunction

  // Expected strobe trace for one accepted sample, first strobe in cycle base.
  function automatic void push_sample(int base);
    obs_t o;
    for (int i = 0; i < TAPS; i++) begin
      o = '0; o.bsy = 1; o.en = 1; o.tap = AW'(i); o.clr = (i == 0); o.sh = (i == 0);
      push(base + i, o, 0);
    end
    o = '0; o.bsy = 1; o.err = 1; o.ov = 1;
    push(base + TAPS, o, 0);
    if (m_planned < m_budget) begin
      for (int i = 0; i < TAPS; i++) begin
        o = '0; o.bsy = 1; o.we = 1; o.tap = AW'(i);
        push(base + TAPS + 1 + i, o, i == TAPS - 1);
      end
      m_planned++;
      if (m_planned == m_budget) begin
        o = '0; o.bsy = 1; o.rdy = 1; o.dn = 1;
        push(base + 2 * TAPS + 1, o, 0);
      end
    end
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      obs_t act, exp_o;
      bit   inc;
      act = {shift_en, mac_clr, mac_en, tap_addr, err_latch, out_valid, coef_we, s_ready, busy, done};
      exp_o = '0; exp_o.rdy = m_running; exp_o.bsy = m_running; inc = 0;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        exp_o = q[0].o;
        inc   = q[0].inc;
        void'(q.pop_front());
      end
      n_vec++;
      if (act !== exp_o || iter_count !== 32'(m_iter) || adapt_active !== m_adapt) begin
        n_fail++;
        $display("FAIL cycle %0d strobes {sh,clr,en,tap,err,ov,we,rdy,busy,done}: got %b iter=%0d adapt=%b, want %b iter=%0d adapt=%b",
                 cyc, act, iter_count, adapt_active, exp_o, m_iter, m_adapt);
      end
      if (coef_we) cnt_we++;
      if (out_valid) cnt_ov++;
      if (done) cnt_done++;
      if (rst) begin
        q.delete(); m_running = 0; m_iter = 0; m_adapt = 0; m_planned = 0;
      end else if (stop) begin
        q.delete(); m_running = 0; m_planned = m_iter;
      end else begin
        if (inc) begin
          m_iter++;
          if (m_iter == m_budget) m_adapt = 0;
        end
        if (!m_running && start) begin
          obs_t o;
          m_running = 1; m_budget = num; m_iter = 0; m_planned = 0; m_adapt = (num > 0);
          if (num <= 0) begin
            o = '0; o.bsy = 1; o.rdy = 1; o.dn = 1;
            push(cyc + 1, o, 0);
          end
        end else if (m_running && exp_o.rdy && s_valid) begin
          push_sample(cyc + 1);
          m_accepts++;
          m_last_acc = cyc + 1;
        end
      end
    end
  end

  // TAPS=101 monitor: handshake legality, tap range, counts and sample spacing.
  int b_shifts[$];
  int b_max_tap = 0, b_we = 0, b_ov = 0, b_dn = 0;
  bit b_prev_hs = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (b_shift_en) begin
        n_vec++;
        if (!b_prev_hs) begin
          n_fail++;
          $display("FAIL b_accept_outside_wait cycle %0d: shift_en=1, want 0 (no handshake)", cyc);
        end
        b_shifts.push_back(cyc);
      end
      if (int'(b_tap_addr) > b_max_tap) b_max_tap = int'(b_tap_addr);
      if (b_coef_we) b_we++;
      if (b_out_valid) b_ov++;
      if (b_done) b_dn++;
      b_prev_hs = b_s_ready && b_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int n);
    rst = 1;
    repeat (n) tick();
    rst = 0;
  endtask

  task automatic pulse_start(int n_it);
    num = n_it;
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic feed(int samples, bit rnd);
    int guard = 0;
    while (m_accepts < samples && guard < 2000) begin
      s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      guard++;
    end
    s_valid = 0;
    if (guard >= 2000) begin
      n_vec++; n_fail++;
      $display("FAIL feed_timeout: accepted %0d, want %0d", m_accepts, samples);
    end
  endtask

  task automatic wait_cycle(int target);
    int guard = 0;
    while (cyc < target && guard < 1000) begin
      tick();
      guard++;
    end
  endtask

  vec_t tbl[5];

  initial begin
    int guard;
    int gaps[4];
    tbl[0] = '{1, 1, 0, 4, 1, 1, 1, 0};
    tbl[1] = '{2, 5, 0, 8, 5, 1, 2, 0};
    tbl[2] = '{0, 2, 0, 0, 2, 1, 0, 0};
    tbl[3] = '{-3, 2, 0, 0, 2, 1, 0, 0};
    tbl[4] = '{3, 3, 1, 12, 3, 1, 3, 0};
    gaps   = '{204, 204, 204, 103};

    rst = 1; start = 0; stop = 0; s_valid = 0; num = 0;
    b_start = 0; b_stop = 0; b_valid = 0; b_num = 0;
    tick();
    mon_en = 1;
    do_reset(2);

    for (int v = 0; v < 5; v++) begin
      do_reset(2);
      cnt_we = 0; cnt_ov = 0; cnt_done = 0; m_accepts = 0;
      pulse_start(tbl[v].num);
      feed(tbl[v].samples, tbl[v].rnd);
      guard = 0;
      while (q.size() > 0 && guard < 1000) begin
        tick();
        guard++;
      end
      repeat (2) tick();
      n_vec++;
      if (guard >= 1000 || cnt_we != tbl[v].exp_we || cnt_ov != tbl[v].exp_ov ||
          cnt_done != tbl[v].exp_done || iter_count !== 32'(tbl[v].exp_iter) ||
          adapt_active !== tbl[v].exp_adapt) begin
        n_fail++;
        $display("FAIL run%0d totals: got we=%0d ov=%0d done=%0d iter=%0d adapt=%b, want we=%0d ov=%0d done=%0d iter=%0d adapt=%b",
                 v, cnt_we, cnt_ov, cnt_done, iter_count, adapt_active,
                 tbl[v].exp_we, tbl[v].exp_ov, tbl[v].exp_done, tbl[v].exp_iter, tbl[v].exp_adapt);
      end
    end

    // rst held 3 cycles from the 2nd UPDATE cycle
    do_reset(2);
    m_accepts = 0;
    pulse_start(1);
    feed(1, 0);
    wait_cycle(m_last_acc + TAPS + 2);
    rst = 1;
    repeat (3) tick();
    rst = 0;
    n_vec++;
    if ({s_ready, shift_en, mac_clr, mac_en, tap_addr, err_latch, out_valid, coef_we,
         adapt_active, busy, done, iter_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_update: busy=%b we=%b iter=%0d adapt=%b rdy=%b, want all 0",
               busy, coef_we, iter_count, adapt_active, s_ready);
    end
    repeat (3) tick();

    // stop during the 2nd UPDATE cycle, then start+stop together
    do_reset(2);
    m_accepts = 0;
    pulse_start(3);
    feed(1, 0);
    wait_cycle(m_last_acc + TAPS + 2);
    stop = 1;
    tick();
    stop = 0;
    n_vec++;
    if (busy !== 1'b0 || coef_we !== 1'b0 || iter_count !== 32'd0 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_mid_update: busy=%b we=%b iter=%0d rdy=%b, want 0 0 0 0",
               busy, coef_we, iter_count, s_ready);
    end
    s_valid = 1;
    repeat (3) tick();
    start = 1; stop = 1; num = 2;
    tick();
    start = 0; stop = 0;
    tick();
    s_valid = 0;
    n_vec++;
    if (busy !== 1'b0 || shift_en !== 1'b0) begin
      n_fail++;
      $display("FAIL start_with_stop: busy=%b shift_en=%b, want 0 0", busy, shift_en);
    end

    // TAPS=101 adapting/frozen throughput
    do_reset(2);
    b_shifts.delete();
    b_max_tap = 0; b_we = 0; b_ov = 0; b_dn = 0;
    b_num = 3;
    b_start = 1;
    tick();
    b_start = 0;
    b_valid = 1;
    guard = 0;
    while (b_shifts.size() < 5 && guard < 5000) begin
      tick();
      guard++;
    end
    b_valid = 0;
    repeat (TAPS_B + 10) tick();
    n_vec++;
    if (b_shifts.size() != 5) begin
      n_fail++;
      $display("FAIL b_samples: got %0d accepted, want 5", b_shifts.size());
    end else begin
      for (int g = 0; g < 4; g++) begin
        n_vec++;
        if (b_shifts[g + 1] - b_shifts[g] != gaps[g]) begin
          n_fail++;
          $display("FAIL b_spacing%0d: got %0d cycles, want %0d", g, b_shifts[g + 1] - b_shifts[g], gaps[g]);
        end
      end
    end
    n_vec++;
    if (b_max_tap != TAPS_B - 1 || b_we != 3 * TAPS_B || b_ov != 5 || b_dn != 1 ||
        b_iter_count !== 32'd3 || b_adapt_active !== 1'b0) begin
      n_fail++;
      $display("FAIL b_totals: got maxtap=%0d we=%0d ov=%0d done=%0d iter=%0d adapt=%b, want 100 303 5 1 3 0",
               b_max_tap, b_we, b_ov, b_dn, b_iter_count, b_adapt_active);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
